// File: rtl/snake_motion_controller.sv
// Snake motion controller: holds the snake body as a register array, advances it
// on move ticks, detects wall and self collisions, and manages lives and the
// IDLE / RUN / RESPAWN / GAMEOVER game flow.
module snake_motion_controller #(
    parameter int COORD_WIDTH    = 10,
    parameter int BLOCK_SIZE     = 10,
    parameter int DISPLAY_WIDTH  = 64,
    parameter int DISPLAY_HEIGHT = 48,
    parameter int MAX_LENGTH     = 63,
    parameter int LENGTH_WIDTH   = 6,
    parameter int RESPAWN_TICKS  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    move_tick,
    input  logic                    dir_valid,
    input  logic [1:0]              dir_in,
    input  logic [LENGTH_WIDTH-1:0] length_in,
    input  logic                    life_up,
    input  logic [LENGTH_WIDTH-1:0] rd_idx,
    output logic [COORD_WIDTH-1:0]  head_x,
    output logic [COORD_WIDTH-1:0]  head_y,
    output logic [COORD_WIDTH-1:0]  rd_x,
    output logic [COORD_WIDTH-1:0]  rd_y,
    output logic [LENGTH_WIDTH-1:0] length,
    output logic [1:0]              lives,
    output logic                    moved,
    output logic                    life_lost,
    output logic                    game_over,
    output logic [1:0]              state
);

    localparam int SEGS    = MAX_LENGTH + 1;
    localparam int START_X = (DISPLAY_WIDTH / 2) * BLOCK_SIZE;
    localparam int START_Y = (DISPLAY_HEIGHT / 2) * BLOCK_SIZE;
    localparam int RW      = $clog2(RESPAWN_TICKS + 1);

    localparam logic signed [COORD_WIDTH:0] STEP  = (COORD_WIDTH + 1)'(BLOCK_SIZE);
    localparam logic signed [COORD_WIDTH:0] MAX_X = (COORD_WIDTH + 1)'(DISPLAY_WIDTH * BLOCK_SIZE);
    localparam logic signed [COORD_WIDTH:0] MAX_Y = (COORD_WIDTH + 1)'(DISPLAY_HEIGHT * BLOCK_SIZE);
    localparam logic signed [COORD_WIDTH:0] ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RUN      = 2'b01,
        ST_RESPAWN  = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    state_t                    cur_state;
    state_t                    next_state;
    dir_t                      dir;
    dir_t                      pending_dir;
    dir_t                      eff_dir;
    logic [COORD_WIDTH-1:0]    seg_x [SEGS];
    logic [COORD_WIDTH-1:0]    seg_y [SEGS];
    logic [RW-1:0]             respawn_cnt;

    logic                      step;
    logic signed [COORD_WIDTH:0] next_hx;
    logic signed [COORD_WIDTH:0] next_hy;
    logic [COORD_WIDTH-1:0]    next_hx_t;
    logic [COORD_WIDTH-1:0]    next_hy_t;
    logic                      wall_hit;
    logic                      self_hit;
    logic                      collide;
    logic [LENGTH_WIDTH-1:0]   length_clamped;
    logic [1:0]                lives_base;
    logic [1:0]                lives_next;
    logic                      respawn_done;
    logic                      reload;
    logic                      reversal;

    // Starting x of segment idx; segments beyond the screen wrap in the coordinate width
    // but are never active with a reachable head position.
    function automatic logic [COORD_WIDTH-1:0] layout_x(input int idx);
        int v;
        v = START_X - BLOCK_SIZE * idx;
        return COORD_WIDTH'(v);
    endfunction

    assign state     = cur_state;
    assign game_over = (cur_state == ST_GAMEOVER);
    assign head_x    = seg_x[0];
    assign head_y    = seg_y[0];
    assign rd_x      = seg_x[rd_idx];
    assign rd_y      = seg_y[rd_idx];

    assign step         = (cur_state == ST_RUN) && move_tick;
    assign respawn_done = (cur_state == ST_RESPAWN) && move_tick &&
                          (respawn_cnt == RW'(RESPAWN_TICKS - 1));
    assign reload       = respawn_done || ((cur_state == ST_GAMEOVER) && start);
    assign collide      = step && (wall_hit || self_hit);
    assign next_hx_t    = next_hx[COORD_WIDTH-1:0];
    assign next_hy_t    = next_hy[COORD_WIDTH-1:0];

    // Candidate head position one grid step along the direction about to take effect.
    always_comb begin
        next_hx = $signed({1'b0, seg_x[0]});
        next_hy = $signed({1'b0, seg_y[0]});
        case (pending_dir)
            DIR_UP:    next_hy = $signed({1'b0, seg_y[0]}) - STEP;
            DIR_RIGHT: next_hx = $signed({1'b0, seg_x[0]}) + STEP;
            DIR_DOWN:  next_hy = $signed({1'b0, seg_y[0]}) + STEP;
            default:   next_hx = $signed({1'b0, seg_x[0]}) - STEP;
        endcase
    end

    // Wall check on the signed candidate so stepping off the left/top edge never wraps.
    always_comb begin
        wall_hit = (next_hx < ZERO) || (next_hx >= MAX_X) ||
                   (next_hy < ZERO) || (next_hy >= MAX_Y);
    end

    // Self check against segments 1..length-2; the tail is skipped because it moves away.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < SEGS - 1; i++) begin
            if (((i + 2) <= int'(length)) &&
                (seg_x[i] == next_hx_t) && (seg_y[i] == next_hy_t)) begin
                self_hit = 1'b1;
            end
        end
    end

    // Target length from the fruit stage, held inside 1..MAX_LENGTH.
    always_comb begin
        length_clamped = length_in;
        if (length_in == '0) begin
            length_clamped = LENGTH_WIDTH'(1);
        end else if (length_in > LENGTH_WIDTH'(MAX_LENGTH)) begin
            length_clamped = LENGTH_WIDTH'(MAX_LENGTH);
        end
    end

    // Lives after an optional extra life, then after an optional collision.
    always_comb begin
        lives_base = lives;
        if (life_up && (cur_state != ST_GAMEOVER)) begin
            lives_base = (lives == 2'd3) ? 2'd3 : lives + 2'd1;
        end
        lives_next = collide ? lives_base - 2'd1 : lives_base;
    end

    // A requested turn is judged against the direction in force after this cycle.
    always_comb begin
        eff_dir  = step ? pending_dir : dir;
        reversal = (dir_in == (eff_dir ^ 2'b10));
    end

    // Next game state.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (start) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (collide) next_state = (lives_next == 2'd0) ? ST_GAMEOVER : ST_RESPAWN;
            end
            ST_RESPAWN: begin
                if (respawn_done) next_state = ST_RUN;
            end
            default: begin
                if (start) next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Body array: reload the starting layout, or shift one step on a clean move.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SEGS; i++) begin
                seg_x[i] <= layout_x(i);
                seg_y[i] <= COORD_WIDTH'(START_Y);
            end
        end else if (reload) begin
            for (int i = 0; i < SEGS; i++) begin
                seg_x[i] <= layout_x(i);
                seg_y[i] <= COORD_WIDTH'(START_Y);
            end
        end else if (step && !collide) begin
            for (int i = 1; i < SEGS; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= next_hx_t;
            seg_y[0] <= next_hy_t;
        end
    end

    // Current and pending direction; reversals of the effective direction are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir         <= DIR_RIGHT;
            pending_dir <= DIR_RIGHT;
        end else if (reload) begin
            dir         <= DIR_RIGHT;
            pending_dir <= DIR_RIGHT;
        end else begin
            if (step) dir <= pending_dir;
            if (dir_valid && !reversal) pending_dir <= dir_t'(dir_in);
        end
    end

    // Active length: follows the fruit stage on every run tick and on respawn.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            length <= LENGTH_WIDTH'(3);
        end else if ((cur_state == ST_GAMEOVER) && start) begin
            length <= LENGTH_WIDTH'(3);
        end else if (respawn_done || step) begin
            length <= length_clamped;
        end
    end

    // Lives counter and the one-cycle moved / life_lost strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lives     <= 2'd3;
            moved     <= 1'b0;
            life_lost <= 1'b0;
        end else begin
            if ((cur_state == ST_GAMEOVER) && start) begin
                lives <= 2'd3;
            end else begin
                lives <= lives_next;
            end
            moved     <= step && !collide;
            life_lost <= collide;
        end
    end

    // Counts move ticks spent paused after a lost life.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            respawn_cnt <= '0;
        end else if (cur_state != ST_RESPAWN) begin
            respawn_cnt <= '0;
        end else if (move_tick) begin
            respawn_cnt <= respawn_done ? '0 : respawn_cnt + RW'(1);
        end
    end

endmodule

// File: tb/tb_snake_motion_controller.sv
// Directed testbench for snake_motion_controller with hand-computed expectations.
module tb_snake_motion_controller;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       move_tick;
    logic       dir_valid;
    logic [1:0] dir_in;
    logic [5:0] length_in;
    logic       life_up;
    logic [5:0] rd_idx;
    logic [9:0] head_x;
    logic [9:0] head_y;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic [5:0] length;
    logic [1:0] lives;
    logic       moved;
    logic       life_lost;
    logic       game_over;
    logic [1:0] state;

    int total_checks;
    int bad_checks;

    snake_motion_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .move_tick (move_tick),
        .dir_valid (dir_valid),
        .dir_in    (dir_in),
        .length_in (length_in),
        .life_up   (life_up),
        .rd_idx    (rd_idx),
        .head_x    (head_x),
        .head_y    (head_y),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .length    (length),
        .lives     (lives),
        .moved     (moved),
        .life_lost (life_lost),
        .game_over (game_over),
        .state     (state)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Counts one comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of strobes from a falling edge, then clears them; returns at the
    // falling edge after the sampling edge so outputs can be checked.
    task automatic applyStimulus(input logic s, input logic mt, input logic dv,
                                 input logic [1:0] d, input logic lu);
        @(negedge clk);
        start     = s;
        move_tick = mt;
        dir_valid = dv;
        dir_in    = d;
        life_up   = lu;
        @(negedge clk);
        start     = 1'b0;
        move_tick = 1'b0;
        dir_valid = 1'b0;
        life_up   = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic turn_and_tick(input logic [1:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, d, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    endtask

    // Directed sequence.
    initial begin
        total_checks = 0;
        bad_checks   = 0;
        reset_n   = 1'b0;
        start     = 1'b0;
        move_tick = 1'b0;
        dir_valid = 1'b0;
        dir_in    = 2'b00;
        length_in = 6'd3;
        life_up   = 1'b0;
        rd_idx    = 6'd2;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        checkOutput("reset_state", state, 0);
        checkOutput("reset_head_x", head_x, 320);
        checkOutput("reset_head_y", head_y, 240);
        checkOutput("reset_seg2_x", rd_x, 300);
        checkOutput("reset_length", length, 3);
        checkOutput("reset_lives", lives, 3);
        checkOutput("reset_moved", moved, 0);
        checkOutput("reset_game_over", game_over, 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        checkOutput("idle_life_up_sat", lives, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        checkOutput("idle_tick_no_move", head_x, 320);

        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("start_run", state, 1);
        rd_idx = 6'd1;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        checkOutput("move1_head_x", head_x, 330);
        checkOutput("move1_head_y", head_y, 240);
        checkOutput("move1_seg1_x", rd_x, 320);
        checkOutput("move1_moved", moved, 1);
        @(negedge clk);
        checkOutput("moved_pulse_clear", moved, 0);

        turn_and_tick(2'b11);
        checkOutput("reversal_rejected_x", head_x, 340);
        checkOutput("reversal_rejected_y", head_y, 240);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("start_ignored_run", state, 1);

        tick_n(29);
        checkOutput("at_edge_x", head_x, 630);
        length_in = 6'd4;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        checkOutput("wall1_life_lost", life_lost, 1);
        checkOutput("wall1_moved", moved, 0);
        checkOutput("wall1_lives", lives, 2);
        checkOutput("wall1_state", state, 2);
        checkOutput("wall1_head_x", head_x, 630);

        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("start_ignored_respawn", state, 2);
        tick_n(1);
        checkOutput("respawn_no_move", head_x, 630);
        tick_n(2);
        checkOutput("respawn_3_state", state, 2);
        tick_n(1);
        checkOutput("respawn_done_state", state, 1);
        checkOutput("respawn_head_x", head_x, 320);
        checkOutput("respawn_head_y", head_y, 240);
        checkOutput("respawn_length", length, 4);

        tick_n(1);
        turn_and_tick(2'b00);
        turn_and_tick(2'b11);
        checkOutput("loop_head_x", head_x, 320);
        checkOutput("loop_head_y", head_y, 230);
        length_in = 6'd5;
        turn_and_tick(2'b10);
        checkOutput("tail_no_collide_moved", moved, 1);
        checkOutput("tail_no_collide_lost", life_lost, 0);
        checkOutput("tail_head_y", head_y, 240);
        checkOutput("tail_length", length, 5);
        rd_idx = 6'd3;
        @(negedge clk);
        checkOutput("seg3_x", rd_x, 330);
        checkOutput("seg3_y", rd_y, 240);
        turn_and_tick(2'b01);
        checkOutput("self_collide_lost", life_lost, 1);
        checkOutput("self_collide_lives", lives, 1);
        checkOutput("self_collide_state", state, 2);
        checkOutput("self_collide_head_x", head_x, 320);

        tick_n(4);
        checkOutput("respawn2_state", state, 1);
        tick_n(31);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        checkOutput("lifeup_wall_lives", lives, 1);
        checkOutput("lifeup_wall_state", state, 2);

        tick_n(4);
        tick_n(32);
        checkOutput("final_hit_lives", lives, 0);
        checkOutput("final_hit_state", state, 3);
        checkOutput("final_hit_game_over", game_over, 1);

        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
        checkOutput("gameover_lives_hold", lives, 0);
        checkOutput("gameover_state_hold", state, 3);
        checkOutput("gameover_head_hold", head_x, 630);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("restart_state", state, 0);
        checkOutput("restart_lives", lives, 3);
        checkOutput("restart_head_x", head_x, 320);
        checkOutput("restart_length", length, 3);
        checkOutput("restart_game_over", game_over, 0);

        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        checkOutput("rerun_state", state, 1);
        @(negedge clk);
        move_tick = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_state", state, 0);
        @(negedge clk);
        move_tick = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        checkOutput("reset_mid_move_head", head_x, 320);
        checkOutput("reset_mid_move_moved", moved, 0);
        checkOutput("reset_mid_move_state", state, 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/snake_motion_controller.md
SNAKE_MOTION_CONTROLLER -- requirements
Module: snake_motion_controller

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- COORD_WIDTH, 10, pixel-coordinate width
- BLOCK_SIZE, 10, pixels per grid step
- DISPLAY_WIDTH, 64, grid columns
- DISPLAY_HEIGHT, 48, grid rows
- MAX_LENGTH, 63, maximum segment index
- LENGTH_WIDTH, 6, length width
- RESPAWN_TICKS, 4, move ticks paused after a life loss
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock
- reset_n, in, 1, asynchronous active-low reset
- start, in, 1, pulse: begin/restart game
- move_tick, in, 1, one-cycle step strobe
- dir_valid, in, 1, dir_in qualifier
- dir_in, in, 2, 00 up, 01 right, 10 down, 11 left
- length_in, in, LENGTH_WIDTH, target length from fruit stage
- life_up, in, 1, pulse: extra life
- rd_idx, in, LENGTH_WIDTH, body read index
- head_x / head_y, out, COORD_WIDTH, segment 0 position
- rd_x / rd_y, out, COORD_WIDTH, combinational read of segment rd_idx
- length, out, LENGTH_WIDTH, active segment count
- lives, out, 2, remaining lives
- moved, out, 1, pulse: body updated this cycle
- life_lost, out, 1, pulse: collision accepted
- game_over, out, 1, level: in GAMEOVER
- state, out, 2, IDLE=00, RUN=01, RESPAWN=10, GAMEOVER=11

Function
REQ-003 Body SHALL be held in a 64-entry register array of (x,y) pairs; segment 0 is the head.
REQ-004 Initial layout SHALL be: segment i = (320 - 10*i, 240) for i = 0..63; dir = right; length = 3.
REQ-005 FSM transitions SHALL be:
- IDLE -> RUN on start
- RUN -> RESPAWN on collision with post-decrement lives > 0
- RUN -> GAMEOVER on collision with post-decrement lives = 0
- RESPAWN -> RUN after RESPAWN_TICKS move_ticks, reloading the REQ-004 layout (length from REQ-011)
- GAMEOVER -> IDLE on start, with lives = 3 and the REQ-004 layout
REQ-006 dir_valid SHALL latch dir_in into pending_dir in any state; a 180-degree reversal of the current dir SHALL be discarded.
REQ-007 On move_tick in RUN: dir <= pending_dir, then next head = head ± BLOCK_SIZE along dir.
REQ-008 Wall collision SHALL apply when next head x is < 0 or >= DISPLAY_WIDTH*BLOCK_SIZE (640), or y is < 0 or >= 480; compute with one extra signed bit, no wrap-around.
REQ-009 Self collision SHALL apply when next head equals any segment 1..length-2; the tail segment (length-1) is excluded because it vacates.
REQ-010 With no collision: segments 1..MAX_LENGTH <= segments 0..MAX_LENGTH-1, segment 0 <= next head, moved = 1 for one cycle; move latency is 1 clk after move_tick.
REQ-011 length SHALL load clamp(length_in, 1, 63) on every move_tick in RUN, applied in the same cycle as the shift.
REQ-012 On collision: body unchanged, moved = 0, life_lost = 1 for one cycle, lives decremented.
REQ-013 life_up SHALL set lives = min(lives+1, 3) in any state except GAMEOVER.
REQ-014 life_up and collision in the same cycle SHALL give lives = min(lives+1, 3) - 1.
REQ-015 move_tick outside RUN SHALL not move the body; in RESPAWN it SHALL only advance the respawn counter.
REQ-016 start while in RUN or RESPAWN SHALL be ignored.

Reset
REQ-017 reset_n low SHALL asynchronously force:
- state = IDLE
- REQ-004 layout; dir = pending_dir = right
- length = 3; lives = 3
- moved = life_lost = game_over = 0
- respawn counter = 0
REQ-018 Assertion mid-move SHALL discard the in-flight update; the first edge after deassertion behaves as IDLE.

Verification
REQ-019 Reset, start, 1 move_tick -> head (330,240), segment 1 (320,240), moved = 1 one cycle later.
REQ-020 In RUN with dir right, dir_in = left, then move_tick -> reversal rejected; head x += 10.
REQ-021 Head at (630,240) dir right, move_tick -> life_lost = 1, lives 3 -> 2, state RESPAWN; after 4 move_ticks, head (320,240), state RUN.
REQ-022 lives = 1 and a wall hit coincident with life_up -> lives = 1, state RESPAWN (not GAMEOVER).
REQ-023 length 5 body forming a loop, head steering into segment 3 -> collision; steering into tail segment 4 -> no collision, moved = 1.
REQ-024 In GAMEOVER, move_tick and life_up -> no change; then start -> IDLE, lives = 3, head (320,240).
